sync_fifo_param: RTL and testbench

SYNC_FIFO_PARAM -- requirements
Module: sync_fifo_param

---
 rtl/sync_fifo_pkg.sv | 32 +++
 rtl/sync_fifo_ram.sv | 52 +++++
 rtl/sync_fifo_param.sv | 197 +++++++++++++++++++
 tb/tb_sync_fifo_param.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/sync_fifo_pkg.sv
// -----------------------------------------------------------------------------
// sync_fifo_pkg
// Shared definitions for the sync_fifo_param block:
//   - level_width()      : width of a level counter that can hold 0..2**depth_width
//   - *_RST constants    : values the status flags take while rst is high
//   - default thresholds : sensible almost-full / almost-empty settings for
//                          integrators that do not drive the thresholds
// -----------------------------------------------------------------------------
package sync_fifo_pkg;

  // One extra bit so that a completely full FIFO (2**depth_width) is representable.
  function automatic int level_width(input int depth_width);
    return depth_width + 1;
  endfunction

  // Flag values held during and right after reset.
  localparam logic FULL_RST   = 1'b0;
  localparam logic AFULL_RST  = 1'b0;
  localparam logic EMPTY_RST  = 1'b1;
  localparam logic AEMPTY_RST = 1'b1;
  localparam logic OVF_RST    = 1'b0;
  localparam logic UNF_RST    = 1'b0;

  // Default threshold settings.
  localparam int AF_MARGIN_DEFAULT = 2;
  localparam int AE_THRESH_DEFAULT = 2;

  function automatic int default_af_thresh(input int depth_width);
    return (2 ** depth_width) - AF_MARGIN_DEFAULT;
  endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// -----------------------------------------------------------------------------
// sync_fifo_ram
// Simple dual-port storage for the FIFO: one write port, one registered read
// port, 2**ADDR_WIDTH x DATA_WIDTH. Written so that synthesis maps it onto a
// block RAM; the read register carries a synchronous reset, which block RAM
// output latches support.
// Ports:
//   clk    : clock, rising edge
//   rst    : synchronous active-high reset of the read register only
//   we     : write enable
//   waddr  : write address
//   wdata  : write word
//   re     : read enable (updates rdata on the edge)
//   raddr  : read address
//   rdata  : registered read word, held while re is low
// -----------------------------------------------------------------------------
module sync_fifo_ram #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 11
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem_r [2**ADDR_WIDTH];

  // Write port: storage is never reset so the array stays RAM-inferable.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  // Read port: read-first on an address collision, which the FIFO relies on
  // when a full FIFO is written and read on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= {DATA_WIDTH{1'b0}};
    end else if (re) begin
      rdata <= mem_r[raddr];
    end else begin
      rdata <= rdata;
    end
  end

endmodule

// File: rtl/sync_fifo_param.sv
// -----------------------------------------------------------------------------
// sync_fifo_param
// Single-clock FIFO with runtime almost-full / almost-empty thresholds, a
// water-level output and sticky overflow / underflow flags.
//
// Build option: define SYNC_FIFO_FWFT_EN for first-word-fall-through reads
// (head word presented on rd_data whenever rd_empty is low; rd_en acknowledges
// it). Without it, rd_data shows the word one cycle after an accepted read.
//
// Ports:
//   clk, rst          : rising-edge clock, synchronous active-high reset
//   wr_en, wr_data    : write request and word
//   wr_full           : level == DEPTH
//   almost_full       : level >= af_thresh
//   af_thresh         : runtime almost-full threshold
//   rd_en             : read request (acknowledge in FWFT builds)
//   rd_data           : read word
//   rd_empty          : no readable word
//   almost_empty      : level <= ae_thresh
//   ae_thresh         : runtime almost-empty threshold
//   water_level       : number of words held
//   overflow/underflow: sticky error flags, cleared by err_clr (a new error wins)
// -----------------------------------------------------------------------------
module sync_fifo_param
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH_WIDTH = 11
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [DATA_WIDTH-1:0]  wr_data,
  output logic                   wr_full,
  output logic                   almost_full,
  input  logic [DEPTH_WIDTH:0]   af_thresh,
  input  logic                   rd_en,
  output logic [DATA_WIDTH-1:0]  rd_data,
  output logic                   rd_empty,
  output logic                   almost_empty,
  input  logic [DEPTH_WIDTH:0]   ae_thresh,
  output logic [DEPTH_WIDTH:0]   water_level,
  output logic                   overflow,
  output logic                   underflow,
  input  logic                   err_clr
);

  localparam int LW = level_width(DEPTH_WIDTH);

  localparam logic [LW-1:0]          LVL_ZERO  = {LW{1'b0}};
  localparam logic [LW-1:0]          LVL_ONE   = {{(LW-1){1'b0}}, 1'b1};
  localparam logic [LW-1:0]          LVL_DEPTH = {1'b1, {DEPTH_WIDTH{1'b0}}};
  localparam logic [DEPTH_WIDTH-1:0] PTR_ZERO  = {DEPTH_WIDTH{1'b0}};
  localparam logic [DEPTH_WIDTH-1:0] PTR_ONE   = {{(DEPTH_WIDTH-1){1'b0}}, 1'b1};

  logic [LW-1:0]          level_r;
  logic [LW-1:0]          next_level_s;
  logic [DEPTH_WIDTH-1:0] wr_ptr_r;
  logic [DEPTH_WIDTH-1:0] rd_ptr_r;
  logic                   wr_full_r;
  logic                   rd_empty_r;
  logic                   almost_full_r;
  logic                   almost_empty_r;
  logic                   overflow_r;
  logic                   underflow_r;
  logic                   wr_accept_s;
  logic                   rd_accept_s;
  logic                   ram_re_s;
  logic                   next_empty_s;

  // Handshake decode. A write into a full FIFO is accepted when a read frees
  // the slot on the same edge, so a full FIFO can stream without losing words.
  always_comb begin
    rd_accept_s = rd_en && !rd_empty_r;
    wr_accept_s = wr_en && (!wr_full_r || rd_accept_s);
  end

  // Next occupancy: +1 write only, -1 read only, unchanged otherwise.
  always_comb begin
    next_level_s = level_r;
    case ({wr_accept_s, rd_accept_s})
      2'b10:   next_level_s = level_r + LVL_ONE;
      2'b01:   next_level_s = level_r - LVL_ONE;
      default: next_level_s = level_r;
    endcase
  end

`ifdef SYNC_FIFO_FWFT_EN
  // The RAM read register doubles as the prefetch register: rd_empty low means
  // it holds the head word. ram_cnt_r counts words still inside the array.
  logic [LW-1:0] ram_cnt_r;
  logic [LW-1:0] next_ram_cnt_s;
  logic          fetch_s;

  // Fetch when the array has a word and the output slot is free or being acknowledged.
  always_comb begin
    fetch_s        = (ram_cnt_r != LVL_ZERO) && (rd_empty_r || rd_accept_s);
    ram_re_s       = fetch_s;
    next_empty_s   = !(fetch_s || (!rd_empty_r && !rd_accept_s));
    next_ram_cnt_s = ram_cnt_r;
    case ({wr_accept_s, fetch_s})
      2'b10:   next_ram_cnt_s = ram_cnt_r + LVL_ONE;
      2'b01:   next_ram_cnt_s = ram_cnt_r - LVL_ONE;
      default: next_ram_cnt_s = ram_cnt_r;
    endcase
  end

  // Array occupancy register.
  always_ff @(posedge clk) begin
    if (rst) begin
      ram_cnt_r <= LVL_ZERO;
    end else begin
      ram_cnt_r <= next_ram_cnt_s;
    end
  end
`else
  // Standard read: the RAM is read on the accepted request itself.
  always_comb begin
    ram_re_s     = rd_accept_s;
    next_empty_s = (next_level_s == LVL_ZERO);
  end
`endif

  // Read and write pointers; natural wrap at DEPTH.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
    end else begin
      wr_ptr_r <= wr_accept_s ? (wr_ptr_r + PTR_ONE) : wr_ptr_r;
      rd_ptr_r <= ram_re_s    ? (rd_ptr_r + PTR_ONE) : rd_ptr_r;
    end
  end

  // Level and status flags, all registered from the next level so they move together.
  always_ff @(posedge clk) begin
    if (rst) begin
      level_r        <= LVL_ZERO;
      wr_full_r      <= FULL_RST;
      rd_empty_r     <= EMPTY_RST;
      almost_full_r  <= AFULL_RST;
      almost_empty_r <= AEMPTY_RST;
    end else begin
      level_r        <= next_level_s;
      wr_full_r      <= (next_level_s == LVL_DEPTH);
      rd_empty_r     <= next_empty_s;
      almost_full_r  <= (next_level_s >= af_thresh);
      almost_empty_r <= (next_level_s <= ae_thresh);
    end
  end

  // Sticky error flags; a new error on the clearing edge keeps the flag set.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_r  <= OVF_RST;
      underflow_r <= UNF_RST;
    end else begin
      if (wr_en && !wr_accept_s) begin
        overflow_r <= 1'b1;
      end else if (err_clr) begin
        overflow_r <= 1'b0;
      end else begin
        overflow_r <= overflow_r;
      end
      if (rd_en && !rd_accept_s) begin
        underflow_r <= 1'b1;
      end else if (err_clr) begin
        underflow_r <= 1'b0;
      end else begin
        underflow_r <= underflow_r;
      end
    end
  end

  sync_fifo_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (DEPTH_WIDTH)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_accept_s),
    .waddr (wr_ptr_r),
    .wdata (wr_data),
    .re    (ram_re_s),
    .raddr (rd_ptr_r),
    .rdata (rd_data)
  );

  assign wr_full      = wr_full_r;
  assign rd_empty     = rd_empty_r;
  assign almost_full  = almost_full_r;
  assign almost_empty = almost_empty_r;
  assign water_level  = level_r;
  assign overflow     = overflow_r;
  assign underflow    = underflow_r;

endmodule

// File: tb/tb_sync_fifo_param.sv
// -----------------------------------------------------------------------------
// tb_sync_fifo_param
// Self-checking bench for sync_fifo_param (DATA_WIDTH=32, DEPTH_WIDTH=4).
// Written words go into a scoreboard queue; accepted reads pop and compare.
// A small occupancy/error model predicts every flag after every edge.
// Define SYNC_FIFO_FWFT_EN to exercise the first-word-fall-through build.
// -----------------------------------------------------------------------------
module tb_sync_fifo_param;

  localparam int DEPTH = 16;

  logic        clk;
  logic        rst;
  logic        wr_en;
  logic [31:0] wr_data;
  logic        wr_full;
  logic        almost_full;
  logic [4:0]  af_thresh;
  logic        rd_en;
  logic [31:0] rd_data;
  logic        rd_empty;
  logic        almost_empty;
  logic [4:0]  ae_thresh;
  logic [4:0]  water_level;
  logic        overflow;
  logic        underflow;
  logic        err_clr;

  int chk_cnt = 0;
  int err_cnt = 0;

  logic [31:0] sb_q[$];
  int          m_lvl;
  logic        m_ovf;
  logic        m_unf;
  logic [31:0] m_rd;

  sync_fifo_param #(.DATA_WIDTH(32), .DEPTH_WIDTH(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .wr_full      (wr_full),
    .almost_full  (almost_full),
    .af_thresh    (af_thresh),
    .rd_en        (rd_en),
    .rd_data      (rd_data),
    .rd_empty     (rd_empty),
    .almost_empty (almost_empty),
    .ae_thresh    (ae_thresh),
    .water_level  (water_level),
    .overflow     (overflow),
    .underflow    (underflow),
    .err_clr      (err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

`ifndef SYNC_FIFO_FWFT_EN
  // Compare every observable output with the model.
  task automatic check_state(input bit after_rst);
    logic exp_af;
    logic exp_ae;
    exp_af = after_rst ? 1'b0 : (m_lvl >= int'(af_thresh));
    exp_ae = after_rst ? 1'b1 : (m_lvl <= int'(ae_thresh));
    check_val("level",     water_level, m_lvl);
    check_val("wr_full",   wr_full,     (m_lvl == DEPTH));
    check_val("rd_empty",  rd_empty,    (m_lvl == 0));
    check_val("alm_full",  almost_full, exp_af);
    check_val("alm_empty", almost_empty, exp_ae);
    check_val("overflow",  overflow,    m_ovf);
    check_val("underflow", underflow,   m_unf);
    check_val("rd_data",   rd_data,     m_rd);
  endtask

  // One clock of stimulus with model update and full check.
  task automatic cycle(input logic we, input logic [31:0] wd, input logic re, input logic clr);
    logic ra;
    logic wa;
    ra = re && (m_lvl > 0);
    wa = we && ((m_lvl < DEPTH) || ra);
    wr_en   = we;
    wr_data = wd;
    rd_en   = re;
    err_clr = clr;
    if (ra) m_rd = sb_q.pop_front();
    if (wa) sb_q.push_back(wd);
    m_lvl = m_lvl + (wa ? 1 : 0) - (ra ? 1 : 0);
    m_ovf = (we && !wa) ? 1'b1 : (clr ? 1'b0 : m_ovf);
    m_unf = (re && !ra) ? 1'b1 : (clr ? 1'b0 : m_unf);
    @(posedge clk);
    #1;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    err_clr = 1'b0;
    check_state(1'b0);
  endtask

  // Reset for one edge while requests are asserted; they must be ignored.
  task automatic do_reset();
    rst     = 1'b1;
    wr_en   = 1'b1;
    rd_en   = 1'b1;
    wr_data = 32'hDEAD_BEEF;
    err_clr = 1'b0;
    @(posedge clk);
    #1;
    rst   = 1'b0;
    wr_en = 1'b0;
    rd_en = 1'b0;
    sb_q.delete();
    m_lvl = 0;
    m_ovf = 1'b0;
    m_unf = 1'b0;
    m_rd  = 32'h0;
    check_state(1'b1);
  endtask
`endif

  initial begin
    rst       = 1'b1;
    wr_en     = 1'b0;
    rd_en     = 1'b0;
    err_clr   = 1'b0;
    wr_data   = 32'h0;
    af_thresh = 5'd12;
    ae_thresh = 5'd3;

`ifdef SYNC_FIFO_FWFT_EN
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_val("rst_empty", rd_empty, 1'b1);
    check_val("rst_data",  rd_data, 32'h0);
    check_val("rst_level", water_level, 5'd0);
    wr_en = 1'b1; wr_data = 32'h0000_1234;
    @(posedge clk); #1;
    wr_en = 1'b0;
    check_val("fw_empty1", rd_empty, 1'b1);
    check_val("fw_level1", water_level, 5'd1);
    @(posedge clk); #1;
    check_val("fw_empty2", rd_empty, 1'b0);
    check_val("fw_data2",  rd_data, 32'h0000_1234);
    wr_en = 1'b1; wr_data = 32'h0000_5678;
    @(posedge clk); #1;
    wr_data = 32'h0000_9ABC;
    @(posedge clk); #1;
    wr_en = 1'b0;
    check_val("fw_hold", rd_data, 32'h0000_1234);
    check_val("fw_level3", water_level, 5'd3);
    rd_en = 1'b1;
    @(posedge clk); #1;
    check_val("fw_data_b", rd_data, 32'h0000_5678);
    check_val("fw_level2", water_level, 5'd2);
    @(posedge clk); #1;
    check_val("fw_data_c", rd_data, 32'h0000_9ABC);
    @(posedge clk); #1;
    check_val("fw_empty_end", rd_empty, 1'b1);
    check_val("fw_level0", water_level, 5'd0);
    check_val("fw_unf0", underflow, 1'b0);
    @(posedge clk); #1;
    rd_en = 1'b0;
    check_val("fw_unf1", underflow, 1'b1);
`else
    @(posedge clk);
    #1;
    do_reset();

    // Fill 0x0..0xF, one extra write, then drain in order.
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 32'(i), 1'b0, 1'b0);
    cycle(1'b1, 32'h0000_0010, 1'b0, 1'b0);
    for (int i = 0; i < DEPTH; i++) cycle(1'b0, 32'h0, 1'b1, 1'b0);

    // Underflow set, clear, and set-wins-over-clear.
    cycle(1'b0, 32'h0, 1'b1, 1'b0);
    cycle(1'b0, 32'h0, 1'b0, 1'b1);
    cycle(1'b0, 32'h0, 1'b1, 1'b0);
    cycle(1'b0, 32'h0, 1'b1, 1'b1);
    cycle(1'b0, 32'h0, 1'b0, 1'b1);

    // Streaming at full across several pointer wraps.
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 32'h100 + 32'(i), 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) cycle(1'b1, 32'h200 + 32'(i), 1'b1, 1'b0);
    for (int i = 0; i < DEPTH; i++) cycle(1'b0, 32'h0, 1'b1, 1'b0);

    // Random traffic with occasional threshold changes and clears.
    for (int i = 0; i < 400; i++) begin
      if ((i % 50) == 0) begin
        af_thresh = 5'($urandom_range(0, 17));
        ae_thresh = 5'($urandom_range(0, 17));
      end
      cycle(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
            1'(($urandom_range(0, 15) == 0) ? 1 : 0));
    end

    // Reset mid-operation at level 9 discards everything.
    af_thresh = 5'd12;
    ae_thresh = 5'd3;
    do_reset();
    for (int i = 0; i < 9; i++) cycle(1'b1, 32'h300 + 32'(i), 1'b0, 1'b0);
    do_reset();
    cycle(1'b1, 32'hA5A5_A5A5, 1'b0, 1'b0);
    cycle(1'b0, 32'h0, 1'b1, 1'b0);
    check_val("post_rst_word", rd_data, 32'hA5A5_A5A5);
    cycle(1'b0, 32'h0, 1'b0, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", chk_cnt, err_cnt);
    $finish;
  end

endmodule
